// File: rtl/ps2_pkg.sv
// Shared constants, receiver state encoding and frame check helper for the PS/2 keyboard.
package ps2_pkg;

    // Scan-code set 2 values the decoder treats specially
    localparam logic [7:0] SC_EXT    = 8'hE0;
    localparam logic [7:0] SC_BREAK  = 8'hF0;
    localparam logic [7:0] SC_LSHIFT = 8'h12;
    localparam logic [7:0] SC_RSHIFT = 8'h59;
    localparam logic [7:0] SC_CAPS   = 8'h58;
    localparam logic [7:0] SC_ENTER  = 8'h5A;

    // start + 8 data + parity + stop
    localparam int unsigned FRAME_BITS = 11;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RECV  = 2'd1,
        CHECK = 2'd2
    } rx_state_e;

    // Frame layout: [0] start, [8:1] data LSB first, [9] odd parity, [10] stop
    function automatic logic frame_ok(input logic [FRAME_BITS-1:0] f);
        return (f[0] == 1'b0) && (f[10] == 1'b1) && ((^f[9:1]) == 1'b1);
    endfunction

endpackage

// File: rtl/ps2_scan_to_ascii.sv
// Combinational scan-code set 2 make code to ASCII lookup (US layout); 0x00 when unmapped.
module ps2_scan_to_ascii
    import ps2_pkg::*;
(
    input  logic [7:0] scan,
    input  logic       shift,
    input  logic       caps,
    output logic [7:0] ascii
);

    logic [7:0] lo;
    logic [7:0] hi;
    logic       letter;

    // Table lookup: letters give only the lowercase value, everything else a plain/shifted pair
    always_comb begin
        lo = 8'h00;
        hi = 8'h00;
        case (scan)
            8'h1C: lo = 8'h61;  8'h32: lo = 8'h62;  8'h21: lo = 8'h63;  8'h23: lo = 8'h64;
            8'h24: lo = 8'h65;  8'h2B: lo = 8'h66;  8'h34: lo = 8'h67;  8'h33: lo = 8'h68;
            8'h43: lo = 8'h69;  8'h3B: lo = 8'h6A;  8'h42: lo = 8'h6B;  8'h4B: lo = 8'h6C;
            8'h3A: lo = 8'h6D;  8'h31: lo = 8'h6E;  8'h44: lo = 8'h6F;  8'h4D: lo = 8'h70;
            8'h15: lo = 8'h71;  8'h2D: lo = 8'h72;  8'h1B: lo = 8'h73;  8'h2C: lo = 8'h74;
            8'h3C: lo = 8'h75;  8'h2A: lo = 8'h76;  8'h1D: lo = 8'h77;  8'h22: lo = 8'h78;
            8'h35: lo = 8'h79;  8'h1A: lo = 8'h7A;
            8'h45: {lo, hi} = {8'h30, 8'h29};
            8'h16: {lo, hi} = {8'h31, 8'h21};
            8'h1E: {lo, hi} = {8'h32, 8'h40};
            8'h26: {lo, hi} = {8'h33, 8'h23};
            8'h25: {lo, hi} = {8'h34, 8'h24};
            8'h2E: {lo, hi} = {8'h35, 8'h25};
            8'h36: {lo, hi} = {8'h36, 8'h5E};
            8'h3D: {lo, hi} = {8'h37, 8'h26};
            8'h3E: {lo, hi} = {8'h38, 8'h2A};
            8'h46: {lo, hi} = {8'h39, 8'h28};
            8'h0E: {lo, hi} = {8'h60, 8'h7E};
            8'h4E: {lo, hi} = {8'h2D, 8'h5F};
            8'h55: {lo, hi} = {8'h3D, 8'h2B};
            8'h54: {lo, hi} = {8'h5B, 8'h7B};
            8'h5B: {lo, hi} = {8'h5D, 8'h7D};
            8'h5D: {lo, hi} = {8'h5C, 8'h7C};
            8'h4C: {lo, hi} = {8'h3B, 8'h3A};
            8'h52: {lo, hi} = {8'h27, 8'h22};
            8'h41: {lo, hi} = {8'h2C, 8'h3C};
            8'h49: {lo, hi} = {8'h2E, 8'h3E};
            8'h4A: {lo, hi} = {8'h2F, 8'h3F};
            8'h29: {lo, hi} = {8'h20, 8'h20};
            SC_ENTER: {lo, hi} = {8'h0D, 8'h0D};
            8'h66: {lo, hi} = {8'h08, 8'h08};
            8'h0D: {lo, hi} = {8'h09, 8'h09};
            8'h76: {lo, hi} = {8'h1B, 8'h1B};
            default: begin
                lo = 8'h00;
                hi = 8'h00;
            end
        endcase
    end

    // Case selection: caps only affects letters
    always_comb begin
        letter = (lo >= 8'h61) && (lo <= 8'h7A);
        if (letter) begin
            ascii = (shift ^ caps) ? (lo - 8'h20) : lo;
        end else begin
            ascii = shift ? hi : lo;
        end
    end

endmodule

// File: rtl/ps2_keyboard.sv
// PS/2 keyboard front end: pin sync, frame receiver, prefix/modifier decoder, ASCII FIFO.
// Optional caps-lock support is enabled by defining PS2_CAPS_LOCK_EN.
module ps2_keyboard
    import ps2_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH     = 8,
    parameter int unsigned TIMEOUT_CYCLES = 50000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    input  logic       ps2_read_done,
    output logic       ps2_read_ready,
    output logic [7:0] data_out,
    output logic       frame_err,
    output logic       overflow
);

    localparam int unsigned AW    = $clog2(FIFO_DEPTH);
    localparam int unsigned PTR_W = AW + 1;
    localparam int unsigned TO_W  = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TO_W-1:0] TO_MAX = TO_W'(TIMEOUT_CYCLES);
    localparam logic [3:0] LAST_BIT = 4'(FRAME_BITS - 1);

    // ---------------- synchronizers ----------------
    logic clk_s1_q, clk_s2_q, clk_prev_q;
    logic dat_s1_q, dat_s2_q;
    logic fall;

    // Two-flop synchronizers plus one history flop for edge detection; idle-high reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            clk_s1_q   <= 1'b1;
            clk_s2_q   <= 1'b1;
            clk_prev_q <= 1'b1;
            dat_s1_q   <= 1'b1;
            dat_s2_q   <= 1'b1;
        end else begin
            clk_s1_q   <= ps2_clk;
            clk_s2_q   <= clk_s1_q;
            clk_prev_q <= clk_s2_q;
            dat_s1_q   <= ps2_data;
            dat_s2_q   <= dat_s1_q;
        end
    end

    assign fall = clk_prev_q & ~clk_s2_q;

    // ---------------- receiver ----------------
    rx_state_e             state_q, state_d;
    logic [FRAME_BITS-1:0] frame_q, frame_d;
    logic [3:0]            bit_cnt_q, bit_cnt_d;
    logic [TO_W-1:0]       to_cnt_q, to_cnt_d;
    logic                  rx_valid_q, rx_valid_d;
    logic [7:0]            rx_byte_q, rx_byte_d;

    // Receiver next-state: shift bits on falling edges, abandon stalled frames
    always_comb begin
        state_d    = state_q;
        frame_d    = frame_q;
        bit_cnt_d  = bit_cnt_q;
        rx_valid_d = 1'b0;
        rx_byte_d  = rx_byte_q;
        if (fall) begin
            to_cnt_d = '0;
        end else if (to_cnt_q != TO_MAX) begin
            to_cnt_d = to_cnt_q + TO_W'(1);
        end else begin
            to_cnt_d = to_cnt_q;
        end
        case (state_q)
            IDLE: begin
                if (fall && !dat_s2_q) begin
                    frame_d   = '0;
                    bit_cnt_d = 4'd1;
                    state_d   = RECV;
                end
            end
            RECV: begin
                if (fall) begin
                    frame_d[bit_cnt_q] = dat_s2_q;
                    bit_cnt_d          = bit_cnt_q + 4'd1;
                    if (bit_cnt_q == LAST_BIT) begin
                        state_d = CHECK;
                    end
                end else if (to_cnt_q == TO_MAX) begin
                    state_d = IDLE;
                end
            end
            CHECK: begin
                state_d = IDLE;
                if (frame_ok(frame_q)) begin
                    rx_valid_d = 1'b1;
                    rx_byte_d  = frame_q[8:1];
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Receiver state registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            frame_q    <= '0;
            bit_cnt_q  <= '0;
            to_cnt_q   <= '0;
            rx_valid_q <= 1'b0;
            rx_byte_q  <= '0;
        end else begin
            state_q    <= state_d;
            frame_q    <= frame_d;
            bit_cnt_q  <= bit_cnt_d;
            to_cnt_q   <= to_cnt_d;
            rx_valid_q <= rx_valid_d;
            rx_byte_q  <= rx_byte_d;
        end
    end

    assign frame_err = (state_q == CHECK) && !frame_ok(frame_q);

    // ---------------- decoder ----------------
    logic       brk_q, brk_d;
    logic       ext_q, ext_d;
    logic       lshift_q, lshift_d;
    logic       rshift_q, rshift_d;
    logic       caps_w;
    logic [7:0] lut_ascii;
    logic       push;
    logic [7:0] push_data;

`ifdef PS2_CAPS_LOCK_EN
    logic caps_q, caps_d;
    assign caps_w = caps_q;
`else
    assign caps_w = 1'b0;
`endif

    ps2_scan_to_ascii u_lookup (
        .scan  (rx_byte_q),
        .shift (lshift_q | rshift_q),
        .caps  (caps_w),
        .ascii (lut_ascii)
    );

    // Decoder: prefixes arm flags, any other byte consumes and clears them
    always_comb begin
        brk_d     = brk_q;
        ext_d     = ext_q;
        lshift_d  = lshift_q;
        rshift_d  = rshift_q;
`ifdef PS2_CAPS_LOCK_EN
        caps_d    = caps_q;
`endif
        push      = 1'b0;
        push_data = lut_ascii;
        if (rx_valid_q) begin
            if (rx_byte_q == SC_EXT) begin
                ext_d = 1'b1;
            end else if (rx_byte_q == SC_BREAK) begin
                brk_d = 1'b1;
            end else begin
                brk_d = 1'b0;
                ext_d = 1'b0;
                if (rx_byte_q == SC_LSHIFT) begin
                    lshift_d = !brk_q;
                end else if (rx_byte_q == SC_RSHIFT) begin
                    rshift_d = !brk_q;
                end else if (!brk_q) begin
                    if (ext_q) begin
                        if (rx_byte_q == SC_ENTER) begin
                            push      = 1'b1;
                            push_data = 8'h0D;
                        end
`ifdef PS2_CAPS_LOCK_EN
                    end else if (rx_byte_q == SC_CAPS) begin
                        caps_d = !caps_q;
`endif
                    end else if (lut_ascii != 8'h00) begin
                        push = 1'b1;
                    end
                end
            end
        end
    end

    // Decoder flag registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            brk_q    <= 1'b0;
            ext_q    <= 1'b0;
            lshift_q <= 1'b0;
            rshift_q <= 1'b0;
        end else begin
            brk_q    <= brk_d;
            ext_q    <= ext_d;
            lshift_q <= lshift_d;
            rshift_q <= rshift_d;
        end
    end

`ifdef PS2_CAPS_LOCK_EN
    // Caps-lock toggle register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            caps_q <= 1'b0;
        end else begin
            caps_q <= caps_d;
        end
    end
`endif

    // ---------------- FIFO ----------------
    logic [7:0]       mem_q [FIFO_DEPTH];
    logic [7:0]       mem_d [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic             ready_q, ready_d;
    logic             overflow_q, overflow_d;
    logic             pop, full, wr_en;

    // FIFO control: a pop frees a slot in the same cycle, so push+pop at full is accepted
    always_comb begin
        pop   = ps2_read_done && ready_q;
        full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
        wr_en = push && (!full || pop);
        mem_d      = mem_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        overflow_d = overflow_q || (push && full && !pop);
        if (wr_en) begin
            mem_d[wr_ptr_q[AW-1:0]] = push_data;
            wr_ptr_d                = wr_ptr_q + PTR_W'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        ready_d = (wr_ptr_d != rd_ptr_d);
    end

    // FIFO storage, pointers and status flags
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_q[i] <= 8'h00;
            end
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            ready_q    <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            mem_q      <= mem_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            ready_q    <= ready_d;
            overflow_q <= overflow_d;
        end
    end

    assign ps2_read_ready = ready_q;
    assign data_out       = mem_q[rd_ptr_q[AW-1:0]];
    assign overflow       = overflow_q;

endmodule
